// File: rtl/victim_line_writeback.sv
// Victim cache drain stage: buffers one evicted line and writes it to memory as a
// single INCR burst, keeping the line visible to chk_hit until the B response arrives.
module victim_line_writeback #(
  parameter int unsigned LINE_WORD_NUM = 16,
  parameter int unsigned TAG_WIDTH     = 20,
  parameter int unsigned INDEX_WIDTH   = 6
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [TAG_WIDTH+INDEX_WIDTH:0]       req_tagvindex,
  input  logic [LINE_WORD_NUM*32-1:0]          req_data,
  input  logic [TAG_WIDTH+INDEX_WIDTH-1:0]     chk_tagindex,
  output logic                                 chk_hit,
  output logic                                 busy,
  output logic                                 done,
  output logic [31:0]                          awaddr,
  output logic [7:0]                           awlen,
  output logic [2:0]                           awsize,
  output logic [1:0]                           awburst,
  output logic                                 awvalid,
  input  logic                                 awready,
  output logic [31:0]                          wdata,
  output logic [3:0]                           wstrb,
  output logic                                 wlast,
  output logic                                 wvalid,
  input  logic                                 wready,
  input  logic                                 bvalid,
  output logic                                 bready
);

  localparam int unsigned TIW  = TAG_WIDTH + INDEX_WIDTH;
  localparam int unsigned CW   = $clog2(LINE_WORD_NUM);
  localparam int unsigned OFFW = 2 + CW;

  if (TIW + OFFW != 32) begin : g_bad_width
    $error("victim_line_writeback: tag+index+offset bits must total 32");
  end

  typedef enum logic [1:0] {IDLE, AW, W, B} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            buf_valid, buf_valid_nx;
  logic            load;
  logic            last_beat;
  logic [TIW-1:0]  buf_ti;
  logic [31:0]     buf_data [LINE_WORD_NUM];

  assign last_beat = (cnt == CW'(LINE_WORD_NUM - 1));

  // Control state; an in-flight line is dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      buf_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      buf_valid <= buf_valid_nx;
    end
  end

  // Line buffer carries no reset; buf_valid qualifies its contents.
  always_ff @(posedge clk) begin
    if (load) begin
      buf_ti <= req_tagvindex[TIW-1:0];
      for (int i = 0; i < int'(LINE_WORD_NUM); i++) begin
        buf_data[i] <= req_data[i*32 +: 32];
      end
    end
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    buf_valid_nx = buf_valid;
    load         = 1'b0;
    req_ready    = 1'b0;
    awvalid      = 1'b0;
    wvalid       = 1'b0;
    bready       = 1'b0;
    done         = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        // Lines with the valid bit clear are consumed and discarded.
        if (req_valid && req_tagvindex[TIW]) begin
          load         = 1'b1;
          buf_valid_nx = 1'b1;
          state_nx     = AW;
        end
      end
      AW: begin
        awvalid = 1'b1;
        if (awready) begin
          cnt_nx   = '0;
          state_nx = W;
        end
      end
      W: begin
        wvalid = 1'b1;
        if (wready) begin
          if (last_beat) state_nx = B;
          else           cnt_nx   = cnt + CW'(1);
        end
      end
      B: begin
        bready = 1'b1;
        if (bvalid) begin
          done         = 1'b1;
          buf_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign chk_hit = buf_valid && (buf_ti == chk_tagindex);
  assign awaddr  = {buf_ti, OFFW'(0)};
  assign awlen   = 8'(LINE_WORD_NUM - 1);
  assign awsize  = 3'b010;
  assign awburst = 2'b01;
  assign wdata   = buf_data[cnt];
  assign wstrb   = 4'hF;
  assign wlast   = (state == W) && last_beat;

endmodule

// File: tb/tb_victim_line_writeback.sv
// Directed bench for victim_line_writeback: stimulus pushes expected AW/W/B traffic
// into queues, an independent monitor pops and compares on every handshake.
module tb_victim_line_writeback;

  localparam int unsigned LW  = 16;
  localparam int unsigned TW  = 20;
  localparam int unsigned IW  = 6;
  localparam int unsigned TIW = TW + IW;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [TIW:0]        req_tagvindex = '0;
  logic [LW*32-1:0]    req_data = '0;
  logic [TIW-1:0]      chk_tagindex = '0;
  logic                chk_hit, busy, done;
  logic [31:0]         awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready = 1'b0;
  logic [31:0]         wdata;
  logic [3:0]          wstrb;
  logic                wlast, wvalid;
  logic                wready = 1'b0;
  logic                bvalid = 1'b0;
  logic                bready;

  always #5 clk = ~clk;

  victim_line_writeback #(.LINE_WORD_NUM(LW), .TAG_WIDTH(TW), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tagvindex(req_tagvindex), .req_data(req_data),
    .chk_tagindex(chk_tagindex), .chk_hit(chk_hit),
    .busy(busy), .done(done),
    .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_aw[$];
  logic [32:0] exp_w[$];
  int exp_done = 0;
  int seen_done = 0;
  int w_seen = 0;
  int b_pending = 0;
  int stall_pct = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Slave-side readies and write response, changed just after the rising edge.
  always @(posedge clk) begin
    #1;
    awready = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
    wready  = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
    bvalid  = (b_pending > 0) && ((stall_pct == 0) || ($urandom_range(99) >= stall_pct));
  end

  // Monitor: samples on the falling edge, where every input and output is settled.
  logic [31:0] prev_awaddr = '0, prev_wdata = '0;
  logic        prev_aw_stall = 1'b0, prev_w_stall = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_aw_stall = 1'b0;
      prev_w_stall  = 1'b0;
      prev_done     = 1'b0;
      b_pending     = 0;
    end else begin
      if (prev_aw_stall) begin
        check("aw_hold_valid", awvalid, 1'b1);
        check("aw_hold_addr", awaddr, prev_awaddr);
      end
      if (prev_w_stall) begin
        check("w_hold_valid", wvalid, 1'b1);
        check("w_hold_data", wdata, prev_wdata);
      end
      if (prev_done) check("ready_after_done", req_ready, 1'b1);
      check("busy_vs_ready", busy, !req_ready);
      if (awvalid) check("no_w_during_aw", wvalid, 1'b0);
      if (awvalid && awready) begin
        if (exp_aw.size() == 0) flag("aw_unexpected");
        else begin
          check("awaddr", awaddr, exp_aw.pop_front());
          check("awlen", awlen, 32'(LW - 1));
          check("awsize", awsize, 3'b010);
          check("awburst", awburst, 2'b01);
        end
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) flag("w_unexpected");
        else begin
          logic [32:0] e;
          e = exp_w.pop_front();
          check("wdata", wdata, e[31:0]);
          check("wlast", wlast, e[32]);
          check("wstrb", wstrb, 4'hF);
        end
        w_seen++;
        if (wlast) b_pending++;
      end
      if (bvalid && bready) begin
        check("done_on_b", done, 1'b1);
        check("no_accept_on_done", req_ready, 1'b0);
        b_pending--;
        seen_done++;
      end else begin
        check("done_low", done, 1'b0);
      end
      prev_aw_stall = awvalid && !awready;
      prev_awaddr   = awaddr;
      prev_w_stall  = wvalid && !wready;
      prev_wdata    = wdata;
      prev_done     = done;
    end
  end

  // Offers one line starting at posedge+1; returns at posedge+1 after acceptance, req_valid still high.
  task automatic send_line(input logic v, input logic [TW-1:0] tag, input logic [IW-1:0] idx,
                           input logic [31:0] base);
    int n = 0;
    req_valid     = 1'b1;
    req_tagvindex = {v, tag, idx};
    for (int i = 0; i < int'(LW); i++) req_data[i*32 +: 32] = base + 32'(i);
    @(negedge clk);
    while (!req_ready && n < 3000) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) flag("accept_timeout");
    else if (v) begin
      exp_aw.push_back({tag, idx, 6'b0});
      for (int i = 0; i < int'(LW); i++) exp_w.push_back({(i == int'(LW) - 1), base + 32'(i)});
      exp_done++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_w.size() != 0 || seen_done != exp_done) && n < 3000);
    if (n >= 3000) flag("idle_timeout");
    check("drained_aw", 32'(exp_aw.size()), 0);
    check("done_count", 32'(seen_done), 32'(exp_done));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cyc;
    int d0;
    int n;
    // Reset state
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid", wvalid, 1'b0);
    check("rst_bready", bready, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_chk_hit", chk_hit, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic line with all readies high, plus latency
    stall_pct = 0;
    send_line(1'b1, 20'hABCDE, 6'h15, 32'h1000);
    req_valid = 1'b0;
    @(negedge clk);
    check("lat_awvalid_c1", awvalid, 1'b1);
    check("lat_awaddr", awaddr, 32'hABCDE540);
    check("lat_wvalid_c1", wvalid, 1'b0);
    @(negedge clk);
    check("lat_wvalid_c2", wvalid, 1'b1);
    check("lat_wdata_c2", wdata, 32'h1000);
    cyc = 2;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("done_latency", 32'(cyc), 32'(LW + 2));
    wait_idle();

    // Random stalls on all three channels
    stall_pct = 30;
    send_line(1'b1, 20'h0F0F0, 6'h01, 32'hA5000000);
    req_valid = 1'b0;
    wait_idle();
    send_line(1'b1, 20'hFFFFF, 6'h3F, 32'hFFFFFFF8);
    req_valid = 1'b0;
    wait_idle();

    // Invalid line is consumed without traffic
    stall_pct = 0;
    send_line(1'b0, 20'h11111, 6'h22, 32'hDEAD0000);
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("inv_busy", busy, 1'b0);
      check("inv_awvalid", awvalid, 1'b0);
    end
    @(posedge clk);
    #1;

    // chk_hit across the line lifetime
    chk_tagindex = {20'h12345, 6'h2A};
    @(negedge clk);
    check("chk_idle", chk_hit, 1'b0);
    @(posedge clk);
    #1;
    send_line(1'b1, 20'h12345, 6'h2A, 32'h00C0FFEE);
    req_valid = 1'b0;
    @(negedge clk);
    check("chk_aw", chk_hit, 1'b1);
    n = 0;
    while (!wvalid && n < 100) begin n++; @(negedge clk); end
    check("chk_w", chk_hit, 1'b1);
    @(posedge clk);
    #1;
    chk_tagindex = {20'h12345, 6'h2B};
    @(negedge clk);
    check("chk_w_diff_idx", chk_hit, 1'b0);
    @(posedge clk);
    #1;
    chk_tagindex = {20'h12345, 6'h2A};
    n = 0;
    do begin @(negedge clk); n++; end while (!(bready && bvalid) && n < 200);
    check("chk_b_handshake", chk_hit, 1'b1);
    @(negedge clk);
    check("chk_after_done", chk_hit, 1'b0);
    wait_idle();

    // Reset in the middle of beat 7, then a fresh line
    d0 = w_seen;
    send_line(1'b1, 20'h55AA5, 6'h0C, 32'h7000);
    req_valid = 1'b0;
    n = 0;
    while (w_seen - d0 < 7 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    rst = 1'b1;
    exp_w.delete();
    exp_aw.delete();
    exp_done--;
    @(negedge clk);
    check("rst_mid_wvalid", wvalid, 1'b0);
    check("rst_mid_req_ready", req_ready, 1'b1);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_chk_hit", chk_hit, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stall_pct = 30;
    send_line(1'b1, 20'h00042, 6'h10, 32'hBEEF0000);
    req_valid = 1'b0;
    wait_idle();

    // Two lines back to back with req_valid held
    d0 = seen_done;
    send_line(1'b1, 20'h3C3C3, 6'h05, 32'h20000);
    send_line(1'b1, 20'hC3C3C, 6'h06, 32'h30000);
    req_valid = 1'b0;
    check("b2b_second_after_first_done", 32'(seen_done), 32'(d0 + 1));
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
